fifo_bridge_tx_encoder: RTL and testbench

//  Write-side feeder for the FIFO bridge inport, in the wclk domain.

---
 rtl/fifo_bridge_tx_encoder_if.sv | 15 +
 rtl/fifo_bridge_tx_encoder.sv | 113 +++++++++++
 tb/tb_fifo_bridge_tx_encoder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_bridge_tx_encoder_if.sv
// Token stream in, code-word stream out toward the FIFO bridge write port.
// slave is the encoder's view; master is the view of whatever drives it.
interface fifo_bridge_tx_encoder_if #(
  parameter int SYMW = 5
) ();
  logic [SYMW-1:0] in_sym;
  logic            in_valid;
  logic            in_ready;
  logic [SYMW-2:0] wdata;
  logic            winc;
  logic            wfull;

  modport master (output in_sym, in_valid, wfull, input in_ready, wdata, winc);
  modport slave  (input in_sym, in_valid, wfull, output in_ready, wdata, winc);
endinterface

// File: rtl/fifo_bridge_tx_encoder.sv
// fifo_bridge_tx_encoder: write-side feeder for the FIFO bridge (wclk domain).
// One-hot tokens are encoded to SYMW-1 bit code words, queued in a small
// circular buffer, and presented to the bridge through a single holding
// register that is held while wfull is high.
// Optional feature macro: TX_ERRCNT_EN (saturating multi-hot token counter).
module fifo_bridge_tx_encoder #(
  parameter int SYMW   = 5,
  parameter int BUF_AW = 2,
  parameter int ERRW   = 8
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  fifo_bridge_tx_encoder_if.slave bus,
  output logic [BUF_AW:0]       buf_level,
  output logic                  busy,
  output logic [ERRW-1:0]       err_cnt
);
  localparam int CW    = SYMW - 1;
  localparam int LW    = BUF_AW + 1;
  localparam int DEPTH = 1 << BUF_AW;
  localparam int CNTW  = $clog2(SYMW + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  logic [CW-1:0]   mem [DEPTH];
  logic [BUF_AW:0] wptr, rptr;
  logic [1:0]      state;
  logic [CW-1:0]   hold;
  logic [CNTW-1:0] ones;
  logic            tok_one, acc, push, pop, empty;

  // Popcount of the token: exactly one bit set is a legal symbol.
  always_comb begin
    ones = '0;
    for (int i = 0; i < SYMW; i++) ones = ones + CNTW'(bus.in_sym[i]);
  end

  assign tok_one      = (ones == CNTW'(1));
  assign buf_level    = wptr - rptr;
  assign empty        = (wptr == rptr);
  assign bus.in_ready = (buf_level != LW'(DEPTH));
  assign acc          = bus.in_valid & bus.in_ready;
  // The MSB token encodes to all-zeros, so the code is simply the low bits.
  assign push         = acc & tok_one;
  // Holder refills when it is empty or its word is consumed this edge.
  assign pop          = ~empty & ((state == IDLE) | ~bus.wfull);
  assign bus.winc     = (state != IDLE);
  assign bus.wdata    = hold;
  assign busy         = ~empty | bus.winc;

  // Buffer storage; contents need no reset, only the pointers do.
  always_ff @(posedge wclk) begin
    if (push) mem[wptr[BUF_AW-1:0]] <= bus.in_sym[CW-1:0];
  end

  // Circular pointers, one extra bit so full and empty differ.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + LW'(1);
      if (pop)  rptr <= rptr + LW'(1);
    end
  end

  // Output stage: hold the current word until the bridge takes it.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            hold  <= mem[rptr[BUF_AW-1:0]];
            state <= bus.wfull ? STALL : SEND;
          end
        end
        SEND, STALL: begin
          if (bus.wfull) begin
            state <= STALL;
          end else if (!empty) begin
            hold  <= mem[rptr[BUF_AW-1:0]];
            state <= SEND;
          end else begin
            hold  <= '1;
            state <= IDLE;
          end
        end
        default: begin
          hold  <= '1;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef TX_ERRCNT_EN
  logic tok_multi;
  assign tok_multi = (ones > CNTW'(1));

  // Saturating count of accepted multi-hot tokens.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n)                              err_cnt <= '0;
    else if (acc && tok_multi && err_cnt != '1) err_cnt <= err_cnt + ERRW'(1);
  end
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_bridge_tx_encoder.sv
// Bench for fifo_bridge_tx_encoder: scenario tasks against a queue model
// built from the token table and the valid/ready and winc/wfull handshakes.
module tb_fifo_bridge_tx_encoder;
  localparam int SYMW = 5, BUF_AW = 2, ERRW = 8;

  logic wclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 wclk = ~wclk;

  fifo_bridge_tx_encoder_if #(.SYMW(SYMW)) bus ();
  logic [BUF_AW:0] buf_level;
  logic            busy;
  logic [ERRW-1:0] err_cnt;

  fifo_bridge_tx_encoder #(.SYMW(SYMW), .BUF_AW(BUF_AW), .ERRW(ERRW)) dut (
    .wclk(wclk), .rst_n(rst_n), .bus(bus),
    .buf_level(buf_level), .busy(busy), .err_cnt(err_cnt)
  );

  int total = 0, bad = 0;
  logic [3:0] exp_q[$], got_q[$];
  int m_err = 0;

  // Token table: {legal, code}
  function automatic logic [4:0] enc(input logic [4:0] s);
    case (s)
      5'b10000: return {1'b1, 4'b0000};
      5'b01000: return {1'b1, 4'b1000};
      5'b00100: return {1'b1, 4'b0100};
      5'b00010: return {1'b1, 4'b0010};
      5'b00001: return {1'b1, 4'b0001};
      default:  return {1'b0, 4'b1111};
    endcase
  endfunction

  function automatic logic [4:0] rnd_tok();
    return 5'b00001 << $urandom_range(0, 4);
  endfunction

  function automatic int exp_err();
`ifdef TX_ERRCNT_EN
    return m_err;
`else
    return 0;
`endif
  endfunction

  task automatic drive(input logic [4:0] s, input logic v, input logic f);
    bus.in_sym = s; bus.in_valid = v; bus.wfull = f;
  endtask

  // Called just after a negedge with inputs set: record handshakes, advance.
  task automatic cyc();
    logic [4:0] e;
    if (bus.in_valid && bus.in_ready) begin
      e = enc(bus.in_sym);
      if (e[4]) exp_q.push_back(e[3:0]);
      else if ($countones(bus.in_sym) > 1 && m_err < (1 << ERRW) - 1) m_err++;
    end
    if (bus.winc && !bus.wfull) begin
      got_q.push_back(bus.wdata);
      total++;
      if (bus.wdata === 4'b1111) begin
        bad++; $display("FAIL reserved_code: wdata=%b driven with winc=1", bus.wdata);
      end
    end
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic drain(input string nm);
    int n;
    drive(5'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100 && (busy || got_q.size() < exp_q.size()); i++) cyc();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_drain_timeout: busy=%b want 0", nm, busy); end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL %s_count: got %0d words want %0d", nm, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL %s_word%0d: got %b want %b", nm, i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    drive(5'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge wclk);
    total++; if (bus.winc !== 1'b0) begin bad++; $display("FAIL rst_winc: got %b want 0", bus.winc); end
    total++; if (bus.wdata !== 4'b1111) begin bad++; $display("FAIL rst_wdata: got %b want 1111", bus.wdata); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    total++; if (buf_level !== 3'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", buf_level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL rst_err: got %0d want 0", err_cnt); end
    rst_n = 1'b1;
    @(negedge wclk);
  endtask

  task automatic test_stream();
    drive(5'b10000, 1'b1, 1'b0); cyc();
    total++; if (bus.winc !== 1'b0) begin bad++; $display("FAIL stream_lat1: winc=%b want 0", bus.winc); end
    drive(5'b01000, 1'b1, 1'b0); cyc();
    total++; if (bus.winc !== 1'b1 || bus.wdata !== 4'b0000) begin
      bad++; $display("FAIL stream_w0: winc=%b wdata=%b want 1/0000", bus.winc, bus.wdata); end
    drive(5'b00001, 1'b1, 1'b0); cyc();
    total++; if (bus.winc !== 1'b1 || bus.wdata !== 4'b1000) begin
      bad++; $display("FAIL stream_w1: winc=%b wdata=%b want 1/1000", bus.winc, bus.wdata); end
    drive(5'b0, 1'b0, 1'b0); cyc();
    total++; if (bus.winc !== 1'b1 || bus.wdata !== 4'b0001) begin
      bad++; $display("FAIL stream_w2: winc=%b wdata=%b want 1/0001", bus.winc, bus.wdata); end
    cyc();
    total++; if (bus.winc !== 1'b0 || bus.wdata !== 4'b1111) begin
      bad++; $display("FAIL stream_end: winc=%b wdata=%b want 0/1111", bus.winc, bus.wdata); end
    drain("stream");
  endtask

  task automatic test_backpressure();
    logic [4:0] t[6];
    logic [4:0] e0;
    int idx = 0;
    logic a;
    for (int i = 0; i < 6; i++) t[i] = rnd_tok();
    e0 = enc(t[0]);
    for (int c = 0; c < 7; c++) begin
      drive(t[(idx < 6) ? idx : 5], idx < 6, 1'b1);
      a = bus.in_ready & bus.in_valid;
      cyc();
      if (a) idx++;
    end
    total++; if (idx != 5) begin bad++; $display("FAIL bp_accepted: got %0d want 5", idx); end
    total++; if (buf_level !== 3'd4) begin bad++; $display("FAIL bp_level: got %0d want 4", buf_level); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    for (int c = 0; c < 2; c++) begin
      total++; if (bus.winc !== 1'b1 || bus.wdata !== e0[3:0]) begin
        bad++; $display("FAIL bp_hold%0d: winc=%b wdata=%b want 1/%b", c, bus.winc, bus.wdata, e0[3:0]); end
      cyc();
    end
    total++; if (exp_q.size() != 5) begin bad++; $display("FAIL bp_model: got %0d want 5", exp_q.size()); end
    drain("bp");
  endtask

  task automatic test_filter();
    drive(5'b00000, 1'b1, 1'b0); cyc();
    drive(5'b11000, 1'b1, 1'b0); cyc();
    drive(5'b00100, 1'b1, 1'b0); cyc();
    total++; if (exp_q.size() != 1) begin bad++; $display("FAIL filt_model: got %0d want 1", exp_q.size()); end
    drain("filt");
    total++; if (int'(err_cnt) != exp_err()) begin
      bad++; $display("FAIL filt_err: got %0d want %0d", err_cnt, exp_err()); end
  endtask

  task automatic test_wrap();
    int n = 0;
    logic [4:0] s;
    logic a;
    s = rnd_tok();
    for (int c = 0; c < 400 && n < 20; c++) begin
      drive(s, 1'b1, $urandom_range(0, 1) == 1);
      a = bus.in_ready;
      cyc();
      if (a) begin
        n++;
        s = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : rnd_tok();
      end
    end
    total++; if (n != 20) begin bad++; $display("FAIL wrap_timeout: accepted %0d want 20", n); end
    drain("wrap");
    total++; if (int'(err_cnt) != exp_err()) begin
      bad++; $display("FAIL wrap_err: got %0d want %0d", err_cnt, exp_err()); end
  endtask

  task automatic test_reset_mid();
    drive(5'b00010, 1'b1, 1'b1); cyc();
    drive(5'b01000, 1'b1, 1'b1); cyc();
    drive(5'b0, 1'b0, 1'b1);
    total++; if (bus.winc !== 1'b1) begin bad++; $display("FAIL midrst_pre: winc=%b want 1", bus.winc); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.winc !== 1'b0) begin bad++; $display("FAIL midrst_winc: got %b want 0", bus.winc); end
    total++; if (buf_level !== 3'd0) begin bad++; $display("FAIL midrst_level: got %0d want 0", buf_level); end
    exp_q.delete(); got_q.delete(); m_err = 0;
    @(negedge wclk);
    rst_n = 1'b1;
    drive(5'b0, 1'b0, 1'b0);
    cyc();
    total++; if (bus.winc !== 1'b0 || bus.wdata !== 4'b1111) begin
      bad++; $display("FAIL midrst_idle: winc=%b wdata=%b want 0/1111", bus.winc, bus.wdata); end
    total++; if (buf_level !== 3'd0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_state: level=%0d busy=%b ready=%b want 0/0/1", buf_level, busy, bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_filter();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
